// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the 4-digit multiplexed 7-segment display controller:
// register offsets, scan FSM state type, the active-low hex segment table and
// the helper that maps a PWM phase and brightness to a scan state.
// Optional feature macro: SEG7_BLINK_EN widens the register address by one bit
// so that the BLINK register at 0x10 is reachable.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

`ifdef SEG7_BLINK_EN
  localparam int ADDR_W = 5;
`else
  localparam int ADDR_W = 4;
`endif

  // Byte offsets of the registers; only bits [4:2] take part in decoding.
  localparam logic [4:0] REG_DATA  = 5'h00;
  localparam logic [4:0] REG_CTRL  = 5'h04;
  localparam logic [4:0] REG_IER   = 5'h08;
  localparam logic [4:0] REG_IFR   = 5'h0C;
  localparam logic [4:0] REG_BLINK = 5'h10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_ON,
    ST_OFF
  } seg7_state_e;

  // Segments a..g in bits 0..6, active low, for nibble values 0..F.
  localparam logic [6:0] HEX_SEG [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Phase 0 is the anti-ghosting guard; phases 1..brightness are lit.
  function automatic seg7_state_e phase_state(input logic [3:0] phase,
                                              input logic [3:0] bright);
    if (phase == 4'd0)
      return ST_BLANK;
    else if (phase <= bright)
      return ST_ON;
    else
      return ST_OFF;
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// seg7_hex_decoder
// Combinational hex nibble + decimal point to active-low segment pattern.
// Ports:
//   nibble  in  4  hex value 0..F
//   dp      in  1  decimal point request (1 = lit)
//   seg_n   out 8  segments a..g = bits 0..6, dp = bit 7, active low
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg_n
);

  assign seg_n = {~dp, HEX_SEG[nibble]};

endmodule

// File: rtl/seg7_display_ctrl.sv
// seg7_display_ctrl
// Register-mapped driver for a 4-digit multiplexed common-anode 7-segment
// display. Each digit slot is 16 PWM phases of PHASE_DIV clocks: phase 0 is a
// blank guard, phases 1..brightness are lit. Display data is double-buffered
// (shadow written by the CPU, live used for scanning) and swapped at the frame
// boundary, which also raises the frame-done flag.
// Optional feature macro: SEG7_BLINK_EN adds the BLINK register at 0x10 and a
// frame counter that blanks masked digits every other 64 frames.
// Ports:
//   clk      in  1   system clock
//   rst_n    in  1   asynchronous active-low reset
//   wr_addr  in  4   write byte address (word select [3:2])
//   wr_en    in  1   write enable
//   wr_data  in  32  write data
//   wr_strb  in  4   byte enables; only full-word writes take effect
//   rd_addr  in  4   read byte address (word select [3:2])
//   rd_en    in  1   read enable
//   rd_data  out 32  combinational read data, 0 when rd_en is low
//   seg_n    out 8   registered segments, active low (dp = bit 7)
//   dig_n    out 4   registered digit anodes, active low
//   irq      out 1   |(ier & ifr)
module seg7_display_ctrl
  import seg7_pkg::*;
#(
  parameter int PHASE_DIV = 6250
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_en,
  input  logic [31:0]       wr_data,
  input  logic [3:0]        wr_strb,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_en,
  output logic [31:0]       rd_data,
  output logic [7:0]        seg_n,
  output logic [3:0]        dig_n,
  output logic              irq
);

  localparam int DIV_W = (PHASE_DIV > 1) ? $clog2(PHASE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(PHASE_DIV - 1);

  logic [19:0]      shadow_data;
  logic [19:0]      live_data;
  logic             ctrl_enable;
  logic [3:0]       ctrl_bright;
  logic [3:0]       ctrl_mask;
  logic [1:0]       ier;
  logic [1:0]       ifr;
  logic [1:0]       ifr_next;
  logic             pend;

  seg7_state_e      state;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       phase;
  logic [1:0]       digit;

  logic [4:0]       wr_off;
  logic [4:0]       rd_off;
  logic             wr_ok;
  logic             wr_data_sel;
  logic             wr_ctrl_sel;
  logic             wr_ier_sel;
  logic             wr_ifr_sel;
  logic             phase_tick;
  logic             frame_tick;
  logic             overrun_set;
  logic             blink_hide;
  logic [3:0]       nibble_sel;
  logic             dp_sel;
  logic [3:0]       dp_bits;
  logic [7:0]       dec_seg_n;

  wire unused_bits = ^{wr_addr[1:0], rd_addr[1:0], wr_data[31:20]};

  assign wr_off      = 5'({wr_addr[ADDR_W-1:2], 2'b00});
  assign rd_off      = 5'({rd_addr[ADDR_W-1:2], 2'b00});
  assign wr_ok       = wr_en && (wr_strb == 4'b1111);
  assign wr_data_sel = wr_ok && (wr_off == REG_DATA);
  assign wr_ctrl_sel = wr_ok && (wr_off == REG_CTRL);
  assign wr_ier_sel  = wr_ok && (wr_off == REG_IER);
  assign wr_ifr_sel  = wr_ok && (wr_off == REG_IFR);

  // The divider only runs while scanning; the frame ends on the tick that
  // leaves phase 15 of digit 3.
  assign phase_tick  = (state != ST_IDLE) && ctrl_enable && (div_cnt == '0);
  assign frame_tick  = phase_tick && (phase == 4'd15) && (digit == 2'd3);

  // A DATA write on the boundary cycle belongs to the next frame, so it
  // cannot overrun the frame that is just ending.
  assign overrun_set = wr_data_sel && ctrl_enable && pend && !frame_tick;

  // Hardware sets take priority over a simultaneous W1C clear.
  always_comb begin
    ifr_next = ifr & ~(wr_ifr_sel ? wr_data[1:0] : 2'b00);
    ifr_next = ifr_next | {overrun_set, frame_tick};
  end

  assign irq = |(ier & ifr);

  // CPU-visible registers and the shadow-to-live data transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_data <= '0;
      live_data   <= '0;
      ctrl_enable <= 1'b0;
      ctrl_bright <= '0;
      ctrl_mask   <= '0;
      ier         <= '0;
      ifr         <= '0;
      pend        <= 1'b0;
    end else begin
      if (wr_data_sel)
        shadow_data <= wr_data[19:0];
      if (wr_ctrl_sel) begin
        ctrl_enable <= wr_data[0];
        ctrl_bright <= wr_data[7:4];
        ctrl_mask   <= wr_data[11:8];
      end
      if (wr_ier_sel)
        ier <= wr_data[1:0];
      ifr <= ifr_next;
      if (state == ST_IDLE || frame_tick)
        live_data <= shadow_data;
      if (wr_data_sel && ctrl_enable)
        pend <= 1'b1;
      else if (frame_tick || state == ST_IDLE)
        pend <= 1'b0;
    end
  end

`ifdef SEG7_BLINK_EN
  logic [3:0] blink_mask;
  logic [5:0] frame_cnt;
  logic       blink_phase;

  // Blink phase flips once every 64 completed frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_mask  <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (wr_ok && (wr_off == REG_BLINK))
        blink_mask <= wr_data[3:0];
      if (frame_tick) begin
        frame_cnt <= frame_cnt + 6'd1;
        if (frame_cnt == 6'd63)
          blink_phase <= ~blink_phase;
      end
    end
  end

  assign blink_hide = blink_phase && blink_mask[digit];
`else
  assign blink_hide = 1'b0;
`endif

  assign dp_bits    = live_data[19:16];
  assign nibble_sel = live_data[{digit, 2'b00} +: 4];
  assign dp_sel     = dp_bits[digit];

  seg7_hex_decoder u_hex_decoder (
    .nibble (nibble_sel),
    .dp     (dp_sel),
    .seg_n  (dec_seg_n)
  );

  // Scan FSM: divider, phase and digit counters plus registered outputs that
  // follow the current state one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      div_cnt <= '0;
      phase   <= '0;
      digit   <= '0;
      seg_n   <= 8'hFF;
      dig_n   <= 4'hF;
    end else begin
      seg_n <= 8'hFF;
      dig_n <= 4'hF;
      if (state == ST_IDLE || !ctrl_enable) begin
        div_cnt <= '0;
        phase   <= '0;
        digit   <= '0;
        if (state == ST_IDLE && ctrl_enable) begin
          state   <= ST_BLANK;
          div_cnt <= DIV_LOAD;
        end else begin
          state <= ST_IDLE;
        end
      end else begin
        if (phase_tick) begin
          div_cnt <= DIV_LOAD;
          phase   <= phase + 4'd1;
          state   <= phase_state(phase + 4'd1, ctrl_bright);
          if (phase == 4'd15)
            digit <= digit + 2'd1;
        end else begin
          div_cnt <= div_cnt - 1'b1;
          state   <= phase_state(phase, ctrl_bright);
        end
        if (state == ST_ON && ctrl_mask[digit] && !blink_hide) begin
          seg_n <= dec_seg_n;
          dig_n <= ~(4'b0001 << digit);
        end
      end
    end
  end

  // Read mux; unmapped offsets and unused bits read as zero.
  always_comb begin
    rd_data = '0;
    if (rd_en) begin
      case (rd_off)
        REG_DATA: rd_data[19:0] = shadow_data;
        REG_CTRL: begin
          rd_data[0]    = ctrl_enable;
          rd_data[7:4]  = ctrl_bright;
          rd_data[11:8] = ctrl_mask;
        end
        REG_IER:  rd_data[1:0] = ier;
        REG_IFR:  rd_data[1:0] = ifr;
`ifdef SEG7_BLINK_EN
        REG_BLINK: rd_data[3:0] = blink_mask;
`endif
        default:  rd_data = '0;
      endcase
    end
  end

endmodule
